// File: rtl/serial_sub_ctrl_pkg.sv
// serial_sub_ctrl_pkg: state encoding and default width shared by the serial subtractor
package serial_sub_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/serial_sub_ctrl_fs_cell.sv
// fs_cell: one-bit full subtractor computing x - y - z
module fs_cell (
  output logic d,
  output logic b_o,
  input  logic x,
  input  logic y,
  input  logic z
);
  assign d   = x ^ y ^ z;
  assign b_o = (~x & y) | (~(x ^ y) & z);
endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial LSB-first subtractor with start/busy/done handshake
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  state_t st;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nx;
  logic [CNT_W-1:0] cnt;
  logic brw, d, bo, accept;
  fs_cell u_cell (.d(d), .b_o(bo), .x(a_sh[0]), .y(b_sh[0]), .z(brw));
  assign accept = start && st != RUN;
  assign res_nx = {d, res_sh[WIDTH-1:1]};
  assign busy   = st == RUN;
  assign done   = st == DONE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st         <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (accept) begin
      st   <= RUN;
      a_sh <= a;
      b_sh <= b;
      brw  <= borrow_in;
      cnt  <= '0;
    end else if (st == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nx;
      brw    <= bo;
      cnt    <= cnt + 1'b1;
      if (cnt == CNT_W'(WIDTH - 1)) begin
        diff       <= res_nx;
        borrow_out <= bo;
        st         <= DONE;
      end
    end else begin
      st <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: scoreboard bench for the serial subtractor and its cell
module tb_serial_sub_ctrl;
  localparam int WIDTH = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic borrow_in = 1'b0;
  logic busy, done, borrow_out;
  logic [WIDTH-1:0] diff;
  logic cx, cy, cz, cd, cb;
  logic [WIDTH:0] sb_q[$];
  int checks = 0;
  int errors = 0;
  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );
  fs_cell u_cell (.d(cd), .b_o(cb), .x(cx), .y(cy), .z(cz));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
      else begin
        logic [WIDTH:0] e;
        e = sb_q.pop_front();
        chk("diff", 32'(diff), 32'(e[WIDTH-1:0]));
        chk("borrow_out", 32'(borrow_out), 32'(e[WIDTH]));
      end
    end
  end
  task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic bin,
                       input logic [7:0] ed, input logic eb);
    start = 1'b1;
    a = av;
    b = bv;
    borrow_in = bin;
    sb_q.push_back({eb, ed});
  endtask
  task automatic wait_done(input int exp_n, input int exp_bc, input string nm);
    int n = 0;
    int bc = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (done) break;
      if (busy) bc++;
      if (n >= 30) break;
    end
    chk({nm, "_latency"}, 32'(n), 32'(exp_n));
    chk({nm, "_busy_cycles"}, 32'(bc), 32'(exp_bc));
  endtask
  task automatic op(input logic [7:0] av, input logic [7:0] bv, input logic bin,
                    input logic [7:0] ed, input logic eb, input string nm);
    @(negedge clk);
    issue(av, bv, bin, ed, eb);
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_busy_first"}, 32'(busy), 32'd1);
    wait_done(8, 7, nm);
  endtask
  initial begin
    logic [7:0] d_tab, b_tab;
    d_tab = 8'b1001_0110;
    b_tab = 8'b1000_1110;
    for (int v = 0; v < 8; v++) begin
      {cx, cy, cz} = 3'(v);
      #1;
      chk($sformatf("cell_d_%0d", v), 32'(cd), 32'(d_tab[v]));
      chk($sformatf("cell_b_%0d", v), 32'(cb), 32'(b_tab[v]));
    end
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
    rst_n = 1'b1;
    op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "basic");
    op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, "neg");
    op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "bin_only");
    op(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, "equal");
    @(negedge clk);
    issue(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    a = 8'hAA;
    b = 8'h00;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, 4, "ign_start");
    repeat (2) @(negedge clk);
    chk("ign_no_restart", 32'(busy), 32'd0);
    @(negedge clk);
    issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
    wait_done(9, 8, "b2b_first");
    issue(8'h01, 8'h02, 1'b0, 8'hFF, 1'b1);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_resume", 32'(busy), 32'd1);
    wait_done(8, 7, "b2b_second");
    @(negedge clk);
    start = 1'b1;
    a = 8'h55;
    b = 8'h22;
    borrow_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_borrow", 32'(borrow_out), 32'd0);
    repeat (12) @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);
    op(8'h55, 8'h22, 1'b0, 8'h33, 1'b0, "after_rst");
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
Bit-serial multi-bit subtractor controller. It computes A - B - borrow_in over WIDTH cycles by sequencing one full-subtractor cell LSB-first. A borrow register chains the cell from one bit to the next. The block trades latency for area in the arithmetic datapath and uses a start/busy/done handshake toward the issuing logic.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)
CNT_W, $clog2(WIDTH+1), width of the bit counter (derived, not overridden)

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  synchronous, active-low reset
start  input  1  request to begin a subtraction; sampled only in IDLE or DONE
a  input  WIDTH  minuend; captured on an accepted start
b  input  WIDTH  subtrahend; captured on an accepted start
borrow_in  input  1  initial borrow; captured on an accepted start
busy  output  1  high while the operation is in RUN
done  output  1  one-cycle completion pulse
diff  output  WIDTH  result of a - b - borrow_in, modulo 2^WIDTH
borrow_out  output  1  final borrow; 1 when a < b + borrow_in as unsigned values

Behaviour:
- Reset: the reset is synchronous and active-low; clk and rst_n are the only clock and reset.
  - rst_n=0 at a rising edge forces state=IDLE.
  - It clears busy, done, diff, borrow_out, the shift registers, the borrow register and the counter to 0.
  - Reset mid-RUN abandons the operation. No done pulse is produced, and diff and borrow_out read 0.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1.
- IDLE transition: start=1 at edge E0 does the following:
  - loads a_sh<=a, b_sh<=b, brw<=borrow_in, cnt<=0;
  - moves to RUN.
  - start=0 stays in IDLE.
- RUN, each edge:
  - the cell is fed X=a_sh[0], Y=b_sh[0], Z=brw;
  - res_sh shifts right with the cell's D output inserted at the MSB;
  - a_sh and b_sh shift right, brw<=cell B output, cnt<=cnt+1.
  - When cnt==WIDTH-1, that edge also writes diff<=final res_sh value, borrow_out<=cell B, and state<=DONE.
- Latency: start sampled at E0 gives busy=1 for exactly WIDTH cycles (E0..E_WIDTH). done=1 for the single cycle after E_WIDTH. Start to done is therefore WIDTH+1 edges.
- DONE:
  - start=1 is accepted as in IDLE, giving back-to-back operation: done drops after one cycle and RUN resumes.
  - Otherwise the next state is IDLE.
- start in RUN is ignored. Operand inputs are don't-care outside an accepted start cycle.
- diff and borrow_out hold the last completed result until the next completion or reset. They never show partial results.
- Cell equations:
  - D = X ^ Y ^ Z
  - B = (~X & Y) | (~(X ^ Y) & Z)
- Wrap-around: the result is modulo 2^WIDTH. The sign is reported only through borrow_out.
- The counter never exceeds WIDTH-1 in RUN. No extra cycles are permitted.

Decomposition:
- Shared package holds:
  - the state encoding typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a default WIDTH constant for the subtract datapath.
- One combinational sub-module, fs_cell (ports d, b_o, x, y, z), instantiated once. Keeping the cell separate lets it be swapped or checked independently.
- Control, counter and shift registers stay in serial_sub_ctrl.

Test Plan (WIDTH=8):
- Basic: a=0x05, b=0x03, borrow_in=0, start for 1 cycle -> busy high 8 cycles, done pulse 9th cycle, diff=0x02, borrow_out=0.
- Negative/wrap: a=0x03, b=0x05, bin=0 -> diff=0xFE, borrow_out=1. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, borrow_out=1. Then a=0xFF, b=0xFF, bin=0 -> diff=0x00, borrow_out=0.
- Ignored start: start a=0x10, b=0x01. Pulse start with a=0xAA, b=0x00 during RUN cycle 3 -> single done, diff=0x0F. No second operation begins.
- Back-to-back: hold start=1 with a=0x80, b=0x01, then a=0x01, b=0x02 presented in the DONE cycle -> first diff=0x7F/borrow 0. Second done 9 edges later, diff=0xFF/borrow 1.
- Reset mid-op: start a=0x55, b=0x22, drive rst_n=0 at RUN cycle 4 for 1 edge -> state IDLE, busy=0, done never pulses, diff=0x00, borrow_out=0. A subsequent start computes correctly (0x33).
- Exhaustive cell check: drive all 8 (x,y,z) combinations into fs_cell -> D/B match the full-subtractor truth table: D=1 for odd parity; B=1 for 001, 010, 011, 111.
